lsu_mem_stage: RTL and testbench

Load/store unit for the MEMORY state of the RV32I multi-cycle core. It accepts one load or store per transaction from the EXECUTE state: an ALU-computed address, rs2 data and the instruction's fun3. It then drives a word-organised data-memory port with byte enables and returns aligned, sign- or zero-extended load data to WRITEBACK. Misaligned or illegal accesses are flagged without touching memory.

---
 rtl/lsu_mem_stage.sv | 83 ++++++++
 tb/tb_lsu_mem_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32I load/store unit driving a word-organised data memory with byte enables
module lsu_mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_fun3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [2:0] fun3;
  logic [1:0] off;
  logic accept, legal, aligned, ok;
  logic [3:0] be_n;
  logic [DATA_WIDTH-1:0] wdata_n, lane, load_n;
  assign req_ready  = state == IDLE;
  assign mem_req    = state == BUSY;
  assign resp_valid = state == RESP;
  assign accept     = req_valid && req_ready;
  always_comb begin
    legal   = req_fun3[1:0] != 2'b11 && (req_is_store ? !req_fun3[2] : !(req_fun3[2] && req_fun3[1]));
    aligned = req_fun3[1:0] == 2'b00 || (req_fun3[1:0] == 2'b01 && !req_addr[0]) ||
              (req_fun3[1:0] == 2'b10 && req_addr[1:0] == 2'b00);
    ok      = legal && aligned;
    be_n    = req_fun3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
              req_fun3[1:0] == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_n = req_fun3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
              req_fun3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    // word loads are always aligned, so the shifted lane is the whole word for LW
    lane    = mem_rdata >> {off, 3'b000};
    load_n  = fun3[1:0] == 2'b00 ? {{24{!fun3[2] && lane[7]}}, lane[7:0]} :
              fun3[1:0] == 2'b01 ? {{16{!fun3[2] && lane[15]}}, lane[15:0]} : lane;
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? (ok ? BUSY : RESP) : IDLE) :
              state == BUSY ? (mem_ack ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fun3       <= '0;
      off        <= '0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        fun3       <= req_fun3;
        off        <= req_addr[1:0];
        resp_rdata <= '0;
        resp_err   <= !ok;
        if (ok) begin
          mem_we    <= req_is_store;
          mem_be    <= be_n;
          mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata <= wdata_n;
        end
      end
      if (state == BUSY && mem_ack) resp_rdata <= mem_we ? '0 : load_n;
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed and randomized checks of lsu_mem_stage against an arithmetic reference model
module tb_lsu_mem_stage;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [2:0] req_fun3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic mem_req, mem_we, mem_ack = 1'b0;
  logic [3:0] mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int checks = 0, passed = 0;
  logic o_req, o_we, o_rdy, o_err;
  logic [3:0] o_be;
  logic [31:0] o_addr, o_wdata, o_rdata;
  int o_lat, o_cnt;

  always #5 clk = ~clk;

  lsu_mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_fun3(req_fun3), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  // access size in bytes is 2**fun3[1:0]; lanes and extension come from plain arithmetic
  task automatic model(input logic st, input logic [2:0] f, input logic [31:0] a, w, r,
                       output logic err, output logic [3:0] be, output logic [31:0] wd, output logic [31:0] rd);
    int sz, o;
    longint v;
    bit legal;
    sz = 1 << f[1:0];
    o = int'(a % 4);
    legal = st ? (f <= 2) : (f <= 2 || f == 4 || f == 5);
    err = !legal || (a % sz != 0);
    be = 4'(((1 << sz) - 1) << o);
    wd = sz == 1 ? w[7:0] * 32'h0101_0101 : sz == 2 ? w[15:0] * 32'h0001_0001 : w;
    v = (longint'(r) >> (8 * o)) & ((64'd1 << (8 * sz)) - 1);
    if (!f[2] && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    rd = (st || err) ? 32'h0 : v[31:0];
  endtask

  task automatic run_txn(input logic st, input logic [2:0] f, input logic [31:0] a, w, r, input int waits);
    int b;
    bit done;
    b = 0; done = 0; o_req = 0; o_rdy = 0; o_lat = -1; o_cnt = 0;
    o_we = 0; o_be = 0; o_addr = 0; o_wdata = 0; o_rdata = 'x; o_err = 'x;
    @(negedge clk);
    req_valid = 1; req_is_store = st; req_fun3 = f; req_addr = a; req_wdata = w;
    @(negedge clk);
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (mem_req) begin
        o_req = 1; o_we = mem_we; o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata;
        mem_ack = b == waits;
        mem_rdata = b == waits ? r : $urandom;
        b++;
      end else mem_ack = 0;
      if (resp_valid) begin
        if (o_cnt == 0) begin o_lat = c; o_rdata = resp_rdata; o_err = resp_err; end
        o_cnt++;
      end else if (o_cnt > 0) done = 1;
      if (req_ready && o_cnt == 0) o_rdy = 1;
      @(negedge clk);
    end
    mem_ack = 0;
  endtask

  task automatic test_reset;
    rst = 1; req_valid = 1; req_fun3 = 3'b010; req_addr = 32'h40;
    repeat (2) @(negedge clk);
    rst = 0; req_valid = 0;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready); else passed++;
    checks++; if ({mem_req, mem_we, mem_be} !== 6'b0) $display("FAIL reset_mem_ctl: got %b expected 0", {mem_req, mem_we, mem_be}); else passed++;
    checks++; if (mem_addr !== 0 || mem_wdata !== 0) $display("FAIL reset_mem_data: got %h/%h expected 0/0", mem_addr, mem_wdata); else passed++;
    checks++; if ({resp_valid, resp_err} !== 2'b0 || resp_rdata !== 0) $display("FAIL reset_resp: got %b%b %h expected 00 0", resp_valid, resp_err, resp_rdata); else passed++;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || resp_valid !== 1'b0) $display("FAIL reset_wins_req: got req=%b resp=%b expected 0 0", mem_req, resp_valid); else passed++;
  endtask

  task automatic test_lb_wait;
    run_txn(0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 3);
    checks++; if (o_addr !== 32'h100) $display("FAIL lb_addr: got %h expected 00000100", o_addr); else passed++;
    checks++; if (o_be !== 4'b1000 || o_we !== 1'b0) $display("FAIL lb_be_we: got %b %b expected 1000 0", o_be, o_we); else passed++;
    checks++; if (o_rdata !== 32'hFFFF_FF80 || o_err !== 1'b0) $display("FAIL lb_rdata: got %h err=%b expected ffffff80 err=0", o_rdata, o_err); else passed++;
    checks++; if (o_lat !== 5 || o_cnt !== 1) $display("FAIL lb_timing: got lat=%0d width=%0d expected 5 1", o_lat, o_cnt); else passed++;
  endtask

  task automatic test_lhu;
    run_txn(0, 3'b101, 32'h202, 32'h0, 32'hBEEF_0000, 0);
    checks++; if (o_be !== 4'b1100) $display("FAIL lhu_be: got %b expected 1100", o_be); else passed++;
    checks++; if (o_rdata !== 32'h0000_BEEF) $display("FAIL lhu_rdata: got %h expected 0000beef", o_rdata); else passed++;
    checks++; if (o_lat !== 2 || o_cnt !== 1) $display("FAIL lhu_timing: got lat=%0d width=%0d expected 2 1", o_lat, o_cnt); else passed++;
  endtask

  task automatic test_sb;
    run_txn(1, 3'b000, 32'h41, 32'h1234_56AB, 32'hDEAD_BEEF, 1);
    checks++; if (o_we !== 1'b1 || o_be !== 4'b0010) $display("FAIL sb_we_be: got %b %b expected 1 0010", o_we, o_be); else passed++;
    checks++; if (o_wdata !== 32'hABAB_ABAB || o_addr !== 32'h40) $display("FAIL sb_data_addr: got %h %h expected ababab ab 00000040", o_wdata, o_addr); else passed++;
    checks++; if (o_rdata !== 0 || o_err !== 1'b0) $display("FAIL sb_resp: got %h err=%b expected 0 err=0", o_rdata, o_err); else passed++;
  endtask

  task automatic test_misaligned;
    run_txn(0, 3'b010, 32'h06, 32'h0, 32'h1111_1111, 0);
    checks++; if (o_err !== 1'b1 || o_rdata !== 0 || o_lat !== 1 || o_req !== 1'b0) $display("FAIL lw_misaligned: got err=%b rd=%h lat=%0d req=%b expected 1 0 1 0", o_err, o_rdata, o_lat, o_req); else passed++;
    run_txn(1, 3'b001, 32'h11, 32'h5555, 32'h0, 0);
    checks++; if (o_err !== 1'b1 || o_rdata !== 0 || o_lat !== 1 || o_req !== 1'b0) $display("FAIL sh_misaligned: got err=%b rd=%h lat=%0d req=%b expected 1 0 1 0", o_err, o_rdata, o_lat, o_req); else passed++;
  endtask

  task automatic test_illegal;
    run_txn(0, 3'b011, 32'h20, 32'h0, 32'h2222_2222, 0);
    checks++; if (o_err !== 1'b1 || o_req !== 1'b0 || o_cnt !== 1) $display("FAIL load_fun3_011: got err=%b req=%b width=%0d expected 1 0 1", o_err, o_req, o_cnt); else passed++;
    run_txn(1, 3'b100, 32'h20, 32'h3333, 32'h0, 0);
    checks++; if (o_err !== 1'b1 || o_req !== 1'b0 || o_cnt !== 1) $display("FAIL store_fun3_100: got err=%b req=%b width=%0d expected 1 0 1", o_err, o_req, o_cnt); else passed++;
  endtask

  task automatic test_reset_busy;
    bit bad;
    bad = 0;
    @(negedge clk);
    req_valid = 1; req_is_store = 1; req_fun3 = 3'b010; req_addr = 32'h80; req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) $display("FAIL rstbusy_req: got %b %h expected 1 00000080", mem_req, mem_addr); else passed++;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; mem_ack = 1;
    checks++; if ({req_ready, mem_req, mem_we, mem_be, resp_valid, resp_err} !== 9'b1_0000_0000 || mem_addr !== 0 || mem_wdata !== 0 || resp_rdata !== 0)
      $display("FAIL rstbusy_outputs: got rdy=%b req=%b we=%b be=%b addr=%h wd=%h rv=%b err=%b rd=%h expected reset values",
               req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_err, resp_rdata); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack = 0;
      if (resp_valid || mem_req || !req_ready) bad = 1;
    end
    checks++; if (bad) $display("FAIL rstbusy_late_ack: got activity after reset expected idle"); else passed++;
    run_txn(0, 3'b010, 32'h84, 32'h0, 32'h0BAD_F00D, 1);
    checks++; if (o_rdata !== 32'h0BAD_F00D || o_err !== 1'b0 || o_lat !== 3 || o_addr !== 32'h84) $display("FAIL rstbusy_next_lw: got rd=%h err=%b lat=%0d addr=%h expected 0badf00d 0 3 00000084", o_rdata, o_err, o_lat, o_addr); else passed++;
  endtask

  task automatic test_random;
    logic st, e_err;
    logic [2:0] f;
    logic [31:0] a, w, r, e_wd, e_rd;
    logic [3:0] e_be;
    int waits;
    for (int n = 0; n < 80; n++) begin
      st = 1'($urandom_range(0, 1)); f = 3'($urandom_range(0, 7));
      a = $urandom; w = $urandom; r = $urandom; waits = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      model(st, f, a, w, r, e_err, e_be, e_wd, e_rd);
      run_txn(st, f, a, w, r, waits);
      checks++; if (o_err !== e_err || o_rdata !== e_rd || o_cnt !== 1 || o_rdy !== 1'b0)
        $display("FAIL rand_resp[%0d]: got err=%b rd=%h width=%0d rdy=%b expected %b %h 1 0", n, o_err, o_rdata, o_cnt, o_rdy, e_err, e_rd); else passed++;
      checks++; if (o_lat !== (e_err ? 1 : waits + 2) || o_req !== !e_err)
        $display("FAIL rand_timing[%0d]: got lat=%0d req=%b expected %0d %b", n, o_lat, o_req, e_err ? 1 : waits + 2, !e_err); else passed++;
      if (!e_err) begin
        checks++; if (o_we !== st || o_be !== e_be || o_addr !== {a[31:2], 2'b00} || (st && o_wdata !== e_wd))
          $display("FAIL rand_mem[%0d]: got we=%b be=%b addr=%h wd=%h expected %b %b %h %h", n, o_we, o_be, o_addr, o_wdata, st, e_be, {a[31:2], 2'b00}, e_wd); else passed++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_lb_wait;
    test_lhu;
    test_sb;
    test_misaligned;
    test_illegal;
    test_reset_busy;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
